// File: rtl/rcfwl_cdc_assert_ctrl_if.sv
// Report channel of the CDC assertion controller: one failing checker id per valid/ready handshake.
interface rcfwl_cdc_assert_ctrl_if #(
    parameter int NUM_CHK = 8
) ();
    localparam int ID_W = $clog2(NUM_CHK);

    logic            rpt_valid;
    logic [ID_W-1:0] rpt_id;
    logic            rpt_ready;

    modport master (output rpt_valid, output rpt_id, input rpt_ready);
    modport slave  (input rpt_valid, input rpt_id, output rpt_ready);
endinterface

// File: rtl/rcfwl_cdc_assert_ctrl.sv
// Global CDC assertion enable sequencer plus sticky failure capture drained
// through a round-robin arbiter onto a single valid/ready report slot.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_DIS    | software disabled; assert_en low, checker failures ignored
// S_SETTLE | wait SETTLE_CYC cycles for checkers to settle; assert_en low
// S_ACTIVE | checking enabled; assert_en high, failures captured
module rcfwl_cdc_assert_ctrl #(
    parameter int NUM_CHK    = 8,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      pok_reset_b,
    input  logic                      sw_disable,
    input  logic [NUM_CHK-1:0]        chk_fail,
    output logic                      assert_en,
    output logic [CNT_W-1:0]          fail_cnt,
    output logic                      overflow,
    rcfwl_cdc_assert_ctrl_if.master   rpt
);
    localparam int ID_W = $clog2(NUM_CHK);
    localparam int IW1  = ID_W + 1;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {S_DIS, S_SETTLE, S_ACTIVE} state_t;

    state_t             state;
    logic [7:0]         settle_cnt;
    logic [NUM_CHK-1:0] pend;
    logic [ID_W-1:0]    rr_ptr;

    logic               active;
    logic               leave_active;
    logic               found;
    logic [ID_W-1:0]    winner;
    logic [IW1-1:0]     idx;
    logic               load;
    logic               handshake;
    logic [NUM_CHK-1:0] clr_vec;
    logic [NUM_CHK-1:0] cap_vec;

    always_ff @(posedge clk or negedge pok_reset_b) begin
        if (!pok_reset_b) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            assert_en  <= 1'b0;
        end else begin
            case (state)
                S_DIS: begin
                    settle_cnt <= '0;
                    assert_en  <= 1'b0;
                    if (!sw_disable) state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (sw_disable) begin
                        state     <= S_DIS;
                        assert_en <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state     <= S_ACTIVE;
                        assert_en <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                S_ACTIVE: begin
                    if (sw_disable) begin
                        state     <= S_DIS;
                        assert_en <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_SETTLE;
                    assert_en <= 1'b0;
                end
            endcase
        end
    end

    assign active       = (state == S_ACTIVE);
    assign leave_active = active & sw_disable;
    assign handshake    = rpt.rpt_valid & rpt.rpt_ready;
    assign cap_vec      = active ? chk_fail : '0;

    // First pending bit at or above rr_ptr, wrapping; idx is one bit wider so the wrap never overflows.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_CHK; k++) begin
            idx = {1'b0, rr_ptr} + IW1'(k);
            if (idx >= IW1'(NUM_CHK)) idx = idx - IW1'(NUM_CHK);
            if (!found && pend[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    assign load    = found & (~rpt.rpt_valid | rpt.rpt_ready);
    assign clr_vec = load ? (NUM_CHK'(1) << winner) : '0;

    always_ff @(posedge clk or negedge pok_reset_b) begin
        if (!pok_reset_b) begin
            pend          <= '0;
            rr_ptr        <= '0;
            rpt.rpt_valid <= 1'b0;
            rpt.rpt_id    <= '0;
            fail_cnt      <= '0;
            overflow      <= 1'b0;
        end else begin
            // A new failure on the bit being granted this cycle stays pending and is not a loss.
            if (leave_active) pend <= '0;
            else              pend <= (pend & ~clr_vec) | cap_vec;

            if (|(cap_vec & pend & ~clr_vec)) overflow <= 1'b1;

            if (load) begin
                rpt.rpt_valid <= 1'b1;
                rpt.rpt_id    <= winner;
                rr_ptr        <= (winner == ID_W'(NUM_CHK - 1)) ? '0 : winner + 1'b1;
            end else if (handshake) begin
                rpt.rpt_valid <= 1'b0;
            end

            if (handshake && (fail_cnt != {CNT_W{1'b1}})) fail_cnt <= fail_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rcfwl_cdc_assert_ctrl.sv
// Directed and randomized check of rcfwl_cdc_assert_ctrl against a behavioural reference model.
module tb_rcfwl_cdc_assert_ctrl;
    localparam int NUM_CHK    = 8;
    localparam int SETTLE_CYC = 16;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               pok_reset_b = 1'b0;
    logic               sw_disable = 1'b0;
    logic [NUM_CHK-1:0] chk_fail = '0;
    logic               assert_en;
    logic [CNT_W-1:0]   fail_cnt;
    logic               overflow;

    rcfwl_cdc_assert_ctrl_if #(.NUM_CHK(NUM_CHK)) rpt ();

    rcfwl_cdc_assert_ctrl #(
        .NUM_CHK    (NUM_CHK),
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .pok_reset_b (pok_reset_b),
        .sw_disable  (sw_disable),
        .chk_fail    (chk_fail),
        .assert_en   (assert_en),
        .fail_cnt    (fail_cnt),
        .overflow    (overflow),
        .rpt         (rpt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: mode 0=disabled, 1=settling, 2=active; m_left counts remaining settle edges.
    int               m_mode;
    int               m_left;
    bit [NUM_CHK-1:0] m_pend;
    int               m_ptr;
    bit               m_valid;
    int               m_id;
    int               m_cnt;
    bit               m_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode  = 1;
        m_left  = SETTLE_CYC;
        m_pend  = '0;
        m_ptr   = 0;
        m_valid = 0;
        m_id    = 0;
        m_cnt   = 0;
        m_ovf   = 0;
    endtask

    task automatic m_step();
        int w;
        bit act, hs, ld;
        bit [NUM_CHK-1:0] np;
        act = (m_mode == 2);
        hs  = m_valid && (rpt.rpt_ready == 1'b1);
        w   = -1;
        for (int k = 0; k < NUM_CHK; k++)
            if (w < 0 && m_pend[(m_ptr + k) % NUM_CHK]) w = (m_ptr + k) % NUM_CHK;
        ld = (w >= 0) && (!m_valid || hs);
        for (int i = 0; i < NUM_CHK; i++) begin
            bit granted;
            granted = ld && (w == i);
            if (act && chk_fail[i] && m_pend[i] && !granted) m_ovf = 1;
            np[i] = (m_pend[i] && !granted) || (act && chk_fail[i]);
        end
        if (act && sw_disable) np = '0;
        m_pend = np;
        if (ld) begin
            m_valid = 1;
            m_id    = w;
            m_ptr   = (w + 1) % NUM_CHK;
        end else if (hs) begin
            m_valid = 0;
        end
        if (hs && m_cnt < CNT_MAX) m_cnt++;
        case (m_mode)
            0: if (!sw_disable) begin m_mode = 1; m_left = SETTLE_CYC; end
            1: if (sw_disable) m_mode = 0;
               else begin
                   m_left--;
                   if (m_left == 0) m_mode = 2;
               end
            default: if (sw_disable) m_mode = 0;
        endcase
    endtask

    task automatic check_model();
        check("m_assert_en", 64'(assert_en), 64'(m_mode == 2));
        check("m_rpt_valid", 64'(rpt.rpt_valid), 64'(m_valid));
        check("m_rpt_id", 64'(rpt.rpt_id), 64'(m_id));
        check("m_fail_cnt", 64'(fail_cnt), 64'(m_cnt));
        check("m_overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic cyc(input logic sw, input logic [NUM_CHK-1:0] f, input logic rdy);
        sw_disable    = sw;
        chk_fail      = f;
        rpt.rpt_ready = rdy;
        @(posedge clk);
        #1;
        m_step();
        check_model();
    endtask

    // Asynchronous reset a few ns after an edge; outputs must clear before the next edge.
    task automatic do_reset();
        #2;
        pok_reset_b = 1'b0;
        #1;
        check("rst_assert_en", 64'(assert_en), 64'd0);
        check("rst_rpt_valid", 64'(rpt.rpt_valid), 64'd0);
        check("rst_rpt_id", 64'(rpt.rpt_id), 64'd0);
        check("rst_fail_cnt", 64'(fail_cnt), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        m_reset();
        @(negedge clk);
        pok_reset_b = 1'b1;
    endtask

    task automatic settle(input logic [NUM_CHK-1:0] f);
        for (int e = 1; e <= SETTLE_CYC; e++) begin
            cyc(1'b0, f, 1'b1);
            check("settle_en", 64'(assert_en), 64'(e == SETTLE_CYC));
            check("settle_valid", 64'(rpt.rpt_valid), 64'd0);
        end
    endtask

    initial begin
        logic sw_r;
        rpt.rpt_ready = 1'b0;
        m_reset();
        #2;
        check("por_assert_en", 64'(assert_en), 64'd0);
        check("por_rpt_valid", 64'(rpt.rpt_valid), 64'd0);
        check("por_fail_cnt", 64'(fail_cnt), 64'd0);
        #10;
        pok_reset_b = 1'b1;

        // Settle with every checker failing: nothing may be captured.
        settle(8'hFF);
        cyc(1'b0, 8'h00, 1'b1);
        check("active_hold", 64'(assert_en), 64'd1);

        // Multi-bit pulse drains as 2,5,7.
        cyc(1'b0, 8'b1010_0100, 1'b1);
        check("burst_lat", 64'(rpt.rpt_valid), 64'd0);
        cyc(1'b0, 8'h00, 1'b1);
        check("burst_id0", 64'(rpt.rpt_id), 64'd2);
        cyc(1'b0, 8'h00, 1'b1);
        check("burst_id1", 64'(rpt.rpt_id), 64'd5);
        cyc(1'b0, 8'h00, 1'b1);
        check("burst_id2", 64'(rpt.rpt_id), 64'd7);
        cyc(1'b0, 8'h00, 1'b1);
        check("burst_empty", 64'(rpt.rpt_valid), 64'd0);
        check("burst_cnt", 64'(fail_cnt), 64'd3);
        check("burst_ovf", 64'(overflow), 64'd0);

        // Round-robin fairness between checkers 0 and 1.
        do_reset();
        settle(8'h00);
        cyc(1'b0, 8'h03, 1'b1);
        for (int g = 0; g < 4; g++) begin
            cyc(1'b0, 8'h03, 1'b1);
            check("rr_id", 64'(rpt.rpt_id), 64'(g % 2));
        end
        check("rr_ovf", 64'(overflow), 64'd1);
        for (int d = 0; d < 3; d++) cyc(1'b0, 8'h00, 1'b1);

        // Back-pressure: id 3 held, repeat failure on 3 overflows.
        do_reset();
        settle(8'h00);
        cyc(1'b0, 8'h08, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check("hold_id", 64'(rpt.rpt_id), 64'd3);
        cyc(1'b0, 8'h08, 1'b0);
        check("hold_ovf0", 64'(overflow), 64'd0);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h08, 1'b0);
        check("hold_ovf1", 64'(overflow), 64'd1);
        check("hold_id2", 64'(rpt.rpt_id), 64'd3);
        check("hold_valid", 64'(rpt.rpt_valid), 64'd1);
        cyc(1'b0, 8'h00, 1'b1);
        check("hold_reid", 64'(rpt.rpt_id), 64'd3);
        check("hold_revalid", 64'(rpt.rpt_valid), 64'd1);
        cyc(1'b0, 8'h00, 1'b1);
        check("hold_drained", 64'(rpt.rpt_valid), 64'd0);
        check("hold_cnt", 64'(fail_cnt), 64'd2);

        // Disable with id 1 in the slot and pend=0C.
        cyc(1'b0, 8'h02, 1'b0);
        cyc(1'b0, 8'h0C, 1'b0);
        check("dis_slot", 64'(rpt.rpt_id), 64'd1);
        cyc(1'b1, 8'h00, 1'b0);
        check("dis_en", 64'(assert_en), 64'd0);
        check("dis_keep", 64'(rpt.rpt_valid), 64'd1);
        cyc(1'b1, 8'h10, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        check("dis_keep_id", 64'(rpt.rpt_id), 64'd1);
        cyc(1'b1, 8'h00, 1'b1);
        check("dis_pend_clr", 64'(rpt.rpt_valid), 64'd0);
        check("dis_cnt", 64'(fail_cnt), 64'd3);
        cyc(1'b0, 8'h00, 1'b0);
        check("reen_en", 64'(assert_en), 64'd0);
        settle(8'h00);

        // Random traffic against the model.
        sw_r = 1'b0;
        for (int r = 0; r < 600; r++) begin
            logic [NUM_CHK-1:0] f;
            if ($urandom_range(0, 99) < 3) sw_r = ~sw_r;
            f = ($urandom_range(0, 2) == 0) ? (NUM_CHK'($urandom) & NUM_CHK'($urandom)) : '0;
            cyc(sw_r, f, logic'($urandom_range(0, 3) != 0));
        end

        // Saturation then reset during a live handshake.
        do_reset();
        settle(8'h00);
        for (int s = 0; s < 300; s++) cyc(1'b0, 8'h01, 1'b1);
        check("sat_cnt", 64'(fail_cnt), 64'd255);
        check("sat_live", 64'(rpt.rpt_valid), 64'd1);
        do_reset();
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h01, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
